mem_bank_burst: RTL and testbench

- Parametrised single-port synchronous memory bank; successor to the fixed 8-bit line and 8x8 / 32x8 / 32x32 memories.
- Adds:
  - configurable word width and depth;
  - registered read with a valid strobe;
  - address-auto-increment burst engine (burst write / burst read) with wrap-around.
- Sits between a controller and datapath as a generic scratch store.

---
 rtl/mem_bank_burst.sv | 217 +++++++++++++++++++++
 tb/tb_mem_bank_burst.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_bank_burst.sv
// Single-port scratch memory with registered read, rvalid strobe and a wrapping
// auto-increment burst engine. Define MEM_BANK_BURST_PARITY_EN for per-word even parity.
module mem_bank_burst #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chsl,
  input  logic               readen,
  input  logic               writen,
  input  logic [ADDR_W-1:0]  adr,
  input  logic [DATA_W-1:0]  data,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               par_inj,
  output logic [DATA_W-1:0]  out,
  output logic               rvalid,
  output logic               busy,
  output logic               done,
  output logic               parity_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BURST_WR = 2'd1,
    S_BURST_RD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] rem_q, rem_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  out_q;
  logic               rvalid_q;
  logic               busy_q;
  logic               done_q;

  logic               start_ok_s;
  logic               acc_wr_s;
  logic               acc_rd_s;
  logic               acc_thru_s;
  logic               last_s;
  logic [ADDR_W-1:0]  acc_addr_s;

  assign start_ok_s = start & chsl & (readen ^ writen);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // rem_q counts accesses still owed after the one in flight; 1 marks the final one
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s && (burst_len != '0)) begin
          state_d = writen ? S_BURST_WR : S_BURST_RD;
          addr_d  = adr + ADDR_W'(1);
          rem_d   = burst_len;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST_WR, S_BURST_RD: begin
        if (!chsl) begin
          state_d = state_q;
        end else if (rem_q == BURST_W'(1)) begin
          state_d = S_IDLE;
          addr_d  = '0;
          rem_d   = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - BURST_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        rem_d   = '0;
      end
    endcase
  end

  always_comb begin
    acc_wr_s   = 1'b0;
    acc_rd_s   = 1'b0;
    acc_thru_s = 1'b0;
    last_s     = 1'b0;
    acc_addr_s = adr;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok_s) begin
            acc_wr_s = writen;
            acc_rd_s = readen;
            last_s   = (burst_len == '0);
          end else begin
            last_s = 1'b0;
          end
        end else if (chsl) begin
          acc_thru_s = readen & writen;
          acc_wr_s   = writen & ~readen;
          acc_rd_s   = readen & ~writen;
        end else begin
          acc_rd_s = 1'b0;
        end
      end
      S_BURST_WR, S_BURST_RD: begin
        acc_addr_s = addr_q;
        if (chsl) begin
          acc_wr_s = (state_q == S_BURST_WR);
          acc_rd_s = (state_q == S_BURST_RD);
          last_s   = (rem_q == BURST_W'(1));
        end else begin
          last_s = 1'b0;
        end
      end
      default: begin
        acc_addr_s = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (acc_wr_s || acc_thru_s) begin
      mem_q[acc_addr_s] <= data;
    end else begin
      mem_q[acc_addr_s] <= mem_q[acc_addr_s];
    end
  end

  // Read data is captured before any same-edge write lands, except write-through
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q    <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (acc_thru_s) begin
        out_q <= data;
      end else if (acc_rd_s) begin
        out_q <= mem_q[acc_addr_s];
      end else begin
        out_q <= out_q;
      end
      rvalid_q <= acc_rd_s | acc_thru_s;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= last_s;
    end
  end

  assign out    = out_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef MEM_BANK_BURST_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q;

  function automatic logic even_par(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= 1'b0;
      end
    end else if (acc_wr_s || acc_thru_s) begin
      par_q[acc_addr_s] <= even_par(data) ^ par_inj;
    end else begin
      par_q[acc_addr_s] <= par_q[acc_addr_s];
    end
  end

  // Write-through returns the just-written word, so its mismatch equals the injection
  always_ff @(posedge clk) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else if (acc_thru_s) begin
      perr_q <= par_inj;
    end else if (acc_rd_s) begin
      perr_q <= par_q[acc_addr_s] ^ even_par(mem_q[acc_addr_s]);
    end else begin
      perr_q <= 1'b0;
    end
  end

  assign parity_err = perr_q;
`else
  logic unused_par_inj_s;
  assign unused_par_inj_s = par_inj;
  assign parity_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bank_burst.sv
// Directed, table-driven bench for mem_bank_burst (default parameters).
module tb_mem_bank_burst;
  logic       clk = 1'b0;
  logic       reset, chsl, readen, writen, start, par_inj;
  logic [4:0] adr;
  logic [7:0] data;
  logic [3:0] burst_len;
  logic [7:0] out;
  logic       rvalid, busy, done, parity_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MEM_BANK_BURST_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_bank_burst #(.DATA_W(8), .ADDR_W(5), .BURST_W(4)) dut (
    .clk(clk), .reset(reset), .chsl(chsl), .readen(readen), .writen(writen),
    .adr(adr), .data(data), .start(start), .burst_len(burst_len), .par_inj(par_inj),
    .out(out), .rvalid(rvalid), .busy(busy), .done(done), .parity_err(parity_err)
  );

  typedef struct {
    string      name;
    logic       rst_n, cs, rd, wr;
    logic [4:0] a;
    logic [7:0] d;
    logic       st;
    logic [3:0] bl;
    logic       pi;
    logic [7:0] e_out;
    logic       e_rv, e_bz, e_dn, e_pe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic c, logic rd, logic wr, logic [4:0] a,
                              logic [7:0] d, logic st, logic [3:0] bl, logic pi,
                              logic [7:0] eo, logic rv, logic bz, logic dn, logic pe);
    vec_t v;
    v.name = n; v.rst_n = r; v.cs = c; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
    v.st = st; v.bl = bl; v.pi = pi; v.e_out = eo; v.e_rv = rv; v.e_bz = bz;
    v.e_dn = dn; v.e_pe = pe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic rd, input logic wr,
                       input logic [4:0] a, input logic [7:0] d, input logic st,
                       input logic [3:0] bl, input logic pi);
    reset = r; chsl = c; readen = rd; writen = wr; adr = a; data = d;
    start = st; burst_len = bl; par_inj = pi;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [7:0] eo, input logic rv,
                         input logic bz, input logic dn, input logic pe);
    chk({nm, ".out"}, out, eo);
    chk({nm, ".rvalid"}, {7'd0, rvalid}, {7'd0, rv});
    chk({nm, ".busy"}, {7'd0, busy}, {7'd0, bz});
    chk({nm, ".done"}, {7'd0, done}, {7'd0, dn});
    chk({nm, ".perr"}, {7'd0, parity_err}, {7'd0, pe});
  endtask

  initial begin
    //                name      rst cs rd wr adr    data   st bl    pi  out    rv bz dn pe
    vecs.push_back(mk("rst0",    0, 0, 0, 0, 5'd0,  8'd0,  0, 4'd0, 0, 8'd0,  0, 0, 0, 0));
    vecs.push_back(mk("wr30",    1, 1, 0, 1, 5'd30, 8'd25, 0, 4'd0, 0, 8'd0,  0, 0, 0, 0));
    vecs.push_back(mk("rstp",    0, 1, 0, 0, 5'd0,  8'd0,  0, 4'd0, 0, 8'd0,  0, 0, 0, 0));
    vecs.push_back(mk("rd30",    1, 1, 1, 0, 5'd30, 8'd0,  0, 4'd0, 0, 8'd0,  1, 0, 0, 0));
    vecs.push_back(mk("wr20",    1, 1, 0, 1, 5'd20, 8'd15, 0, 4'd0, 0, 8'd0,  0, 0, 0, 0));
    vecs.push_back(mk("rd20",    1, 1, 1, 0, 5'd20, 8'd0,  0, 4'd0, 0, 8'd15, 1, 0, 0, 0));
    vecs.push_back(mk("rdcs0",   1, 0, 1, 0, 5'd20, 8'd0,  0, 4'd0, 0, 8'd15, 0, 0, 0, 0));
    vecs.push_back(mk("thru10",  1, 1, 1, 1, 5'd10, 8'd18, 0, 4'd0, 0, 8'd18, 1, 0, 0, 0));
    vecs.push_back(mk("idle",    1, 0, 0, 0, 5'd0,  8'd0,  0, 4'd0, 0, 8'd18, 0, 0, 0, 0));
    vecs.push_back(mk("rd20b",   1, 1, 1, 0, 5'd20, 8'd0,  0, 4'd0, 0, 8'd15, 1, 0, 0, 0));
    vecs.push_back(mk("rd10",    1, 1, 1, 0, 5'd10, 8'd0,  0, 4'd0, 0, 8'd18, 1, 0, 0, 0));
    vecs.push_back(mk("bw0",     1, 1, 0, 1, 5'd30, 8'd1,  1, 4'd3, 0, 8'd18, 0, 1, 0, 0));
    vecs.push_back(mk("bw1",     1, 1, 1, 0, 5'd5,  8'd2,  1, 4'd0, 0, 8'd18, 0, 1, 0, 0));
    vecs.push_back(mk("bw2",     1, 1, 0, 1, 5'd5,  8'd3,  0, 4'd0, 0, 8'd18, 0, 1, 0, 0));
    vecs.push_back(mk("bw3",     1, 1, 0, 1, 5'd5,  8'd4,  0, 4'd0, 0, 8'd18, 0, 0, 1, 0));
    vecs.push_back(mk("bwend",   1, 0, 0, 0, 5'd0,  8'd0,  0, 4'd0, 0, 8'd18, 0, 0, 0, 0));
    vecs.push_back(mk("chk30",   1, 1, 1, 0, 5'd30, 8'd0,  0, 4'd0, 0, 8'd1,  1, 0, 0, 0));
    vecs.push_back(mk("chk31",   1, 1, 1, 0, 5'd31, 8'd0,  0, 4'd0, 0, 8'd2,  1, 0, 0, 0));
    vecs.push_back(mk("chk0",    1, 1, 1, 0, 5'd0,  8'd0,  0, 4'd0, 0, 8'd3,  1, 0, 0, 0));
    vecs.push_back(mk("chk1",    1, 1, 1, 0, 5'd1,  8'd0,  0, 4'd0, 0, 8'd4,  1, 0, 0, 0));
    vecs.push_back(mk("chk2",    1, 1, 1, 0, 5'd2,  8'd0,  0, 4'd0, 0, 8'd0,  1, 0, 0, 0));
    vecs.push_back(mk("chk5",    1, 1, 1, 0, 5'd5,  8'd0,  0, 4'd0, 0, 8'd0,  1, 0, 0, 0));
    vecs.push_back(mk("br0",     1, 1, 1, 0, 5'd30, 8'd0,  1, 4'd3, 0, 8'd1,  1, 1, 0, 0));
    vecs.push_back(mk("br1",     1, 1, 1, 0, 5'd9,  8'd0,  0, 4'd0, 0, 8'd2,  1, 1, 0, 0));
    vecs.push_back(mk("brpause", 1, 0, 1, 0, 5'd9,  8'd0,  0, 4'd0, 0, 8'd2,  0, 1, 0, 0));
    vecs.push_back(mk("br2",     1, 1, 1, 0, 5'd9,  8'd0,  0, 4'd0, 0, 8'd3,  1, 1, 0, 0));
    vecs.push_back(mk("br3",     1, 1, 1, 0, 5'd9,  8'd0,  0, 4'd0, 0, 8'd4,  1, 0, 1, 0));
    vecs.push_back(mk("brend",   1, 0, 0, 0, 5'd0,  8'd0,  0, 4'd0, 0, 8'd4,  0, 0, 0, 0));
    vecs.push_back(mk("bl0",     1, 1, 0, 1, 5'd7,  8'h77, 1, 4'd0, 0, 8'd4,  0, 0, 1, 0));
    vecs.push_back(mk("bl0rd",   1, 1, 1, 0, 5'd7,  8'd0,  0, 4'd0, 0, 8'h77, 1, 0, 0, 0));
    vecs.push_back(mk("badst",   1, 1, 1, 1, 5'd7,  8'h11, 1, 4'd2, 0, 8'h77, 0, 0, 0, 0));
    vecs.push_back(mk("badcs",   1, 0, 0, 1, 5'd7,  8'h22, 1, 4'd2, 0, 8'h77, 0, 0, 0, 0));
    vecs.push_back(mk("rd7",     1, 1, 1, 0, 5'd7,  8'd0,  0, 4'd0, 0, 8'h77, 1, 0, 0, 0));

    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
            vecs[i].st, vecs[i].bl, vecs[i].pi);
      chk_all(vecs[i].name, vecs[i].e_out, vecs[i].e_rv, vecs[i].e_bz, vecs[i].e_dn,
              vecs[i].e_pe);
    end

    // Reset lands on the third access of an 8-word burst write
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 8'hA0, 1'b1, 4'd7, 1'b0);
    chk_all("abrt0", 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 8'hA1, 1'b0, 4'd0, 1'b0);
    chk_all("abrt1", 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 8'hA2, 1'b0, 4'd0, 1'b0);
    chk_all("abrtrst", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    chk_all("abrtpost", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 5'(a), 8'd0, 1'b0, 4'd0, 1'b0);
      chk($sformatf("clr%0d", a), out, 8'd0);
      chk($sformatf("clrv%0d", a), {7'd0, rvalid}, 8'd1);
    end

    // Fresh burst after reset, then a new start issued in the done cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 8'd9, 1'b1, 4'd1, 1'b0);
    chk_all("nbw0", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd20, 8'd10, 1'b0, 4'd0, 1'b0);
    chk_all("nbw1", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 8'd0, 1'b1, 4'd1, 1'b0);
    chk_all("nbr0", 8'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd20, 8'd0, 1'b0, 4'd0, 1'b0);
    chk_all("nbr1", 8'd10, 1'b1, 1'b0, 1'b1, 1'b0);

    // Parity injection: only the injected word reports an error (when parity is built in)
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 8'hA5, 1'b0, 4'd0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 8'h3C, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 8'd0, 1'b0, 4'd0, 1'b0);
    chk_all("prd5", 8'hA5, 1'b1, 1'b0, 1'b0, PAR_ON);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 8'd0, 1'b0, 4'd0, 1'b0);
    chk_all("prd6", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 8'd0, 1'b1, 4'd1, 1'b0);
    chk_all("pbr0", 8'hA5, 1'b1, 1'b1, 1'b0, PAR_ON);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    chk_all("pbr1", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    chk_all("pidle", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
